// File: rtl/render_scheduler.sv
// rtl/render_scheduler.sv - job FIFO and sequencer feeding render_rect / character_renderer onto one VGA port
// Optional abort watchdog selected by defining RENDER_WATCHDOG_EN.
module render_scheduler #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3,
    parameter int CHAR_W  = 8,
    parameter int SIZE_W  = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 20000
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_kind,
    input  logic [X_W-1:0]     cmd_x,
    input  logic [Y_W-1:0]     cmd_y,
    input  logic [X_W-1:0]     cmd_w,
    input  logic [Y_W-1:0]     cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               cmd_border,
    input  logic [COLOR_W-1:0] cmd_bcolor,
    input  logic [CHAR_W-1:0]  cmd_char,
    input  logic [SIZE_W-1:0]  cmd_size,
    output logic               job_kind,
    output logic [X_W-1:0]     job_x,
    output logic [Y_W-1:0]     job_y,
    output logic [X_W-1:0]     job_w,
    output logic [Y_W-1:0]     job_h,
    output logic [COLOR_W-1:0] job_color,
    output logic               job_border,
    output logic [COLOR_W-1:0] job_bcolor,
    output logic [CHAR_W-1:0]  job_char,
    output logic [SIZE_W-1:0]  job_size,
    output logic               rect_enable,
    output logic               text_enable,
    input  logic               rect_finished,
    input  logic               text_finished,
    input  logic [X_W-1:0]     rect_px_x,
    input  logic [Y_W-1:0]     rect_px_y,
    input  logic [COLOR_W-1:0] rect_px_color,
    input  logic               rect_px_plot,
    input  logic [X_W-1:0]     text_px_x,
    input  logic [Y_W-1:0]     text_px_y,
    input  logic               text_px_plot,
    output logic [X_W-1:0]     out_x,
    output logic [Y_W-1:0]     out_y,
    output logic [COLOR_W-1:0] out_color,
    output logic               plot,
    output logic               busy,
    output logic               err_timeout
);
    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = 1 + 2*X_W + 2*Y_W + 2*COLOR_W + 1 + CHAR_W + SIZE_W;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;
    state_t state, state_next;

    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic               fifo_empty, fifo_full, push, pop;
    logic [ENTRY_W-1:0] cmd_entry, head;

    logic               h_kind;
    logic [X_W-1:0]     h_x, h_w;
    logic [Y_W-1:0]     h_y, h_h;
    logic [COLOR_W-1:0] h_color, h_bcolor;
    logic               h_border;
    logic [CHAR_W-1:0]  h_char;
    logic [SIZE_W-1:0]  h_size;

    logic job_done, wd_expire, next_kind;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;

    assign cmd_entry = {cmd_kind, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
                        cmd_border, cmd_bcolor, cmd_char, cmd_size};
    assign head      = fifo_mem[rd_ptr[AW-1:0]];
    assign {h_kind, h_x, h_y, h_w, h_h, h_color, h_border, h_bcolor, h_char, h_size} = head;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= cmd_entry;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    assign job_done = job_kind ? text_finished : rect_finished;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            S_IDLE:  if (!fifo_empty) state_next = S_LOAD;
            S_LOAD: begin
                pop        = 1'b1;
                state_next = S_RUN;
            end
            S_RUN:   if (job_done || wd_expire) state_next = S_DRAIN;
            S_DRAIN: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            job_kind   <= 1'b0;
            job_x      <= '0;
            job_y      <= '0;
            job_w      <= '0;
            job_h      <= '0;
            job_color  <= '0;
            job_border <= 1'b0;
            job_bcolor <= '0;
            job_char   <= '0;
            job_size   <= '0;
        end else if (state == S_LOAD) begin
            job_kind   <= h_kind;
            job_x      <= h_x;
            job_y      <= h_y;
            job_w      <= h_w;
            job_h      <= h_h;
            job_color  <= h_color;
            job_border <= h_border;
            job_bcolor <= h_bcolor;
            job_char   <= h_char;
            job_size   <= h_size;
        end
    end

    // Enables are registered so they rise on the same edge the job fields land.
    assign next_kind = (state == S_LOAD) ? h_kind : job_kind;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rect_enable <= 1'b0;
            text_enable <= 1'b0;
        end else begin
            rect_enable <= (state_next == S_RUN) && !next_kind;
            text_enable <= (state_next == S_RUN) && next_kind;
        end
    end

`ifdef RENDER_WATCHDOG_EN
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);
    logic [15:0] wd_cnt;
    logic        err_q;

    // wd_cnt holds the number of RUN cycles already completed for this job.
    assign wd_expire   = (state == S_RUN) && (wd_cnt == WD_LIMIT);
    assign err_timeout = err_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == S_LOAD) begin
                wd_cnt <= '0;
            end else if (state == S_RUN) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            if (wd_expire && !job_done) err_q <= 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg  = (TIMEOUT == 0);
    assign wd_expire   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign busy = (state != S_IDLE) || !fifo_empty;

    always_comb begin
        out_x     = '0;
        out_y     = '0;
        out_color = '0;
        plot      = 1'b0;
        if (rect_enable) begin
            out_x     = rect_px_x;
            out_y     = rect_px_y;
            out_color = rect_px_color;
            plot      = rect_px_plot;
        end else if (text_enable) begin
            out_x     = text_px_x;
            out_y     = text_px_y;
            out_color = job_color;
            plot      = text_px_plot;
        end
    end
endmodule

// File: tb/tb_render_scheduler.sv
// tb/tb_render_scheduler.sv - randomized bench for render_scheduler against a queue-based reference model
`timescale 1ns/1ps
module tb_render_scheduler;
    localparam int X_W = 8, Y_W = 7, COLOR_W = 3, CHAR_W = 8, SIZE_W = 4;
    localparam int DEPTH = 4, TIMEOUT = 16;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready;
    logic cmd_kind = 1'b0, cmd_border = 1'b0;
    logic [X_W-1:0] cmd_x = '0, cmd_w = '0;
    logic [Y_W-1:0] cmd_y = '0, cmd_h = '0;
    logic [COLOR_W-1:0] cmd_color = '0, cmd_bcolor = '0;
    logic [CHAR_W-1:0] cmd_char = '0;
    logic [SIZE_W-1:0] cmd_size = '0;
    logic job_kind, job_border;
    logic [X_W-1:0] job_x, job_w;
    logic [Y_W-1:0] job_y, job_h;
    logic [COLOR_W-1:0] job_color, job_bcolor;
    logic [CHAR_W-1:0] job_char;
    logic [SIZE_W-1:0] job_size;
    logic rect_enable, text_enable;
    logic rect_finished = 1'b0, text_finished = 1'b0;
    logic [X_W-1:0] rect_px_x = '0, text_px_x = '0, out_x;
    logic [Y_W-1:0] rect_px_y = '0, text_px_y = '0, out_y;
    logic [COLOR_W-1:0] rect_px_color = '0, out_color;
    logic rect_px_plot = 1'b0, text_px_plot = 1'b0, plot, busy, err_timeout;

    render_scheduler #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .CHAR_W(CHAR_W),
                       .SIZE_W(SIZE_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .cmd_border(cmd_border), .cmd_bcolor(cmd_bcolor),
        .cmd_char(cmd_char), .cmd_size(cmd_size),
        .job_kind(job_kind), .job_x(job_x), .job_y(job_y), .job_w(job_w), .job_h(job_h),
        .job_color(job_color), .job_border(job_border), .job_bcolor(job_bcolor),
        .job_char(job_char), .job_size(job_size),
        .rect_enable(rect_enable), .text_enable(text_enable),
        .rect_finished(rect_finished), .text_finished(text_finished),
        .rect_px_x(rect_px_x), .rect_px_y(rect_px_y), .rect_px_color(rect_px_color),
        .rect_px_plot(rect_px_plot), .text_px_x(text_px_x), .text_px_y(text_px_y),
        .text_px_plot(text_px_plot), .out_x(out_x), .out_y(out_y), .out_color(out_color),
        .plot(plot), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic               kind;
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [X_W-1:0]     w;
        logic [Y_W-1:0]     h;
        logic [COLOR_W-1:0] color;
        logic               border;
        logic [COLOR_W-1:0] bcolor;
        logic [CHAR_W-1:0]  chr;
        logic [SIZE_W-1:0]  size;
        int                 t;
    } job_t;

    // Model: pending jobs with their push edge, the active job, and edge stamps.
    job_t q[$];
    job_t act = '0;
    bit   act_on = 1'b0;
    bit   m_err = 1'b0;
    int   n = 0, avail = 0, start_e = 0, drain_e = -10;

    int errors = 0, checks = 0, obs_acc = 0;
    bit hold_off = 1'b0;
    int r_cnt = 0, t_cnt = 0, r_lat = 1, t_lat = 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        bit re, te;
        logic [63:0] px_exp;
        re = act_on && !act.kind;
        te = act_on && act.kind;
        check("cmd_ready", 64'(cmd_ready), 64'(q.size() < DEPTH));
        check("rect_enable", 64'(rect_enable), 64'(re));
        check("text_enable", 64'(text_enable), 64'(te));
        check("busy", 64'(busy), 64'(act_on || q.size() != 0 || drain_e == n));
        check("err_timeout", 64'(err_timeout), 64'(m_err));
        check("job_fields",
              64'({job_kind, job_x, job_y, job_w, job_h, job_color, job_border, job_bcolor, job_char, job_size}),
              64'({act.kind, act.x, act.y, act.w, act.h, act.color, act.border, act.bcolor, act.chr, act.size}));
        if (re)      px_exp = 64'({rect_px_x, rect_px_y, rect_px_color, rect_px_plot});
        else if (te) px_exp = 64'({text_px_x, text_px_y, act.color, text_px_plot});
        else         px_exp = 64'(0);
        check("pixel_mux", 64'({out_x, out_y, out_color, plot}), px_exp);
    endtask

    task automatic model_edge();
        bit   fin;
        bit   acc;
        int   ready_e;
        job_t j;
        n++;
        if (!resetn) begin
            q.delete();
            act = '0;
            act_on = 1'b0;
            m_err = 1'b0;
            drain_e = -10;
            avail = n;
            return;
        end
        acc = cmd_valid && (q.size() < DEPTH);
        if (act_on) begin
            fin = act.kind ? text_finished : rect_finished;
            if (fin) begin
                act_on = 1'b0; avail = n + 1; drain_e = n;
            end
`ifdef RENDER_WATCHDOG_EN
            else if (n - start_e >= TIMEOUT) begin
                act_on = 1'b0; avail = n + 1; drain_e = n; m_err = 1'b1;
            end
`endif
        end else if (q.size() > 0) begin
            ready_e = (avail > q[0].t) ? avail : q[0].t;
            if (n >= ready_e + 2) begin
                act = q.pop_front();
                act_on = 1'b1;
                start_e = n;
            end
        end
        if (acc) begin
            j = '{kind: cmd_kind, x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color,
                  border: cmd_border, bcolor: cmd_bcolor, chr: cmd_char, size: cmd_size, t: n};
            q.push_back(j);
        end
    endtask

    // Engine emulation: finished after a random latency, held until enable drops.
    // The idle engine's finished line carries random noise that must be ignored.
    task automatic drive_engines();
        if (rect_enable) begin
            r_cnt++;
            if (r_cnt == 1) r_lat = $urandom_range(1, 6);
        end else r_cnt = 0;
        if (text_enable) begin
            t_cnt++;
            if (t_cnt == 1) t_lat = $urandom_range(1, 6);
        end else t_cnt = 0;
        rect_finished = (rect_enable && r_cnt >= r_lat && !hold_off) || (text_enable && 1'($urandom));
        text_finished = (text_enable && t_cnt >= t_lat && !hold_off) || (rect_enable && 1'($urandom));
        rect_px_x = X_W'($urandom);      rect_px_y = Y_W'($urandom);
        rect_px_color = COLOR_W'($urandom); rect_px_plot = 1'($urandom);
        text_px_x = X_W'($urandom);      text_px_y = Y_W'($urandom);
        text_px_plot = 1'($urandom);
    endtask

    task automatic cycle();
        @(negedge clock);
        check_outputs();
        if (cmd_valid && cmd_ready) obs_acc++;
        @(posedge clock);
        model_edge();
        #1;
        drive_engines();
    endtask

    task automatic rand_cmd();
        cmd_kind = 1'($urandom);    cmd_x = X_W'($urandom);   cmd_y = Y_W'($urandom);
        cmd_w = X_W'($urandom);     cmd_h = Y_W'($urandom);   cmd_color = COLOR_W'($urandom);
        cmd_border = 1'($urandom);  cmd_bcolor = COLOR_W'($urandom);
        cmd_char = CHAR_W'($urandom); cmd_size = SIZE_W'($urandom);
    endtask

    task automatic set_cmd(input logic kind, input int x, input int y, input int w, input int h,
                           input int color, input logic border, input int chr, input int size);
        cmd_kind = kind; cmd_x = X_W'(x); cmd_y = Y_W'(y); cmd_w = X_W'(w); cmd_h = Y_W'(h);
        cmd_color = COLOR_W'(color); cmd_border = border; cmd_bcolor = COLOR_W'(1);
        cmd_char = CHAR_W'(chr); cmd_size = SIZE_W'(size);
    endtask

    initial begin
        // Reset with a job offered: nothing may be accepted.
        resetn = 1'b0;
        cmd_valid = 1'b1;
        rand_cmd();
        @(posedge clock); #1;
        repeat (3) cycle();
        resetn = 1'b1;
        cmd_valid = 1'b0;
        repeat (3) cycle();

        // Single rect job.
        set_cmd(1'b0, 10, 20, 4, 3, 4, 1'b0, 0, 0);
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        repeat (14) cycle();

        // Rect followed back-to-back by a glyph.
        set_cmd(1'b0, 5, 6, 7, 8, 3, 1'b1, 0, 0);
        cmd_valid = 1'b1;
        cycle();
        set_cmd(1'b1, 30, 40, 0, 0, 2, 1'b0, 8'h41, 2);
        cycle();
        cmd_valid = 1'b0;
        repeat (30) cycle();

        // Capacity: engines stalled, producer always offering.
        hold_off = 1'b1;
        obs_acc = 0;
        cmd_valid = 1'b1;
        repeat (10) begin
            rand_cmd();
            cycle();
        end
        check("fill_accepted", 64'(obs_acc), 64'(DEPTH + 1));
        cmd_valid = 1'b0;
        hold_off = 1'b0;
        repeat (60) cycle();

        // Asynchronous reset while a job runs with three queued behind it.
        hold_off = 1'b1;
        cmd_valid = 1'b1;
        repeat (4) begin
            rand_cmd();
            cycle();
        end
        cmd_valid = 1'b0;
        repeat (3) cycle();
        check("pre_reset_active", 64'(rect_enable | text_enable), 64'(1));
        #2 resetn = 1'b0;
        #1;
        check("async_rect_enable", 64'(rect_enable), 64'(0));
        check("async_text_enable", 64'(text_enable), 64'(0));
        check("async_busy", 64'(busy), 64'(0));
        check("async_cmd_ready", 64'(cmd_ready), 64'(1));
        @(posedge clock);
        model_edge();
        #1;
        drive_engines();
        resetn = 1'b1;
        hold_off = 1'b0;
        repeat (20) cycle();

`ifdef RENDER_WATCHDOG_EN
        // Engines never finish: both jobs must be aborted by the watchdog.
        hold_off = 1'b1;
        cmd_valid = 1'b1;
        rand_cmd();
        cycle();
        rand_cmd();
        cycle();
        cmd_valid = 1'b0;
        repeat (45) cycle();
        check("wd_err_sticky", 64'(err_timeout), 64'(1));
        hold_off = 1'b0;
        repeat (5) cycle();
`endif

        // Randomized traffic.
        repeat (300) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            rand_cmd();
            cycle();
        end
        cmd_valid = 1'b0;
        repeat (60) cycle();
        check("final_idle_busy", 64'(busy), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
